// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the 4-digit display driver.
// Optional build macro BCD_SATURATE_EN: clamp the displayed digits at 9999 on overflow instead of wrapping modulo 10000.
module bin_to_bcd #(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = 9999
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic             out_valid,
    output logic             ovf
);

    localparam int SRW = 20 + WIDTH;
    localparam int CW  = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]     state;
    logic [SRW-1:0] sr;
    logic [SRW-1:0] adjusted;
    logic [CW-1:0]  count;
    logic           ovf_next;

    assign in_ready = (state == IDLE);

    // Add-3 correction on every BCD nibble (including ten-thousands) before the shift.
    always_comb begin
        adjusted = sr;
        for (int i = 0; i < 5; i++) begin
            if (sr[WIDTH + 4*i +: 4] >= 4'd5) begin
                adjusted[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= '0;
            ovf_next  <= 1'b0;
            ones      <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= {20'd0, bin_in};
                        ovf_next <= (bin_in > WIDTH'(MAXVAL));
                        count    <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    sr    <= adjusted << 1;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef BCD_SATURATE_EN
                    if (ovf_next) begin
                        ones      <= 4'd9;
                        tens      <= 4'd9;
                        hundreds  <= 4'd9;
                        thousands <= 4'd9;
                    end else begin
                        ones      <= sr[WIDTH      +: 4];
                        tens      <= sr[WIDTH + 4  +: 4];
                        hundreds  <= sr[WIDTH + 8  +: 4];
                        thousands <= sr[WIDTH + 12 +: 4];
                    end
`else
                    // Ten-thousands nibble is dropped, so overflowing inputs show modulo 10000.
                    ones      <= sr[WIDTH      +: 4];
                    tens      <= sr[WIDTH + 4  +: 4];
                    hundreds  <= sr[WIDTH + 8  +: 4];
                    thousands <= sr[WIDTH + 12 +: 4];
`endif
                    ovf       <= ovf_next;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: vector table applied back-to-back, scoreboard of expected digits, plus
// hand-written sequences for reset abort and mid-conversion requests.
module tb_bin_to_bcd;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] digits;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] EXP_12345 = 16'h9999;
    localparam logic [15:0] EXP_16383 = 16'h9999;
`else
    localparam logic [15:0] EXP_12345 = 16'h2345;
    localparam logic [15:0] EXP_16383 = 16'h6383;
`endif

    logic        clk = 1'b0;
    logic        RESET;
    logic [13:0] bin_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        out_valid;
    logic        ovf;

    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   cycle = 0;
    exp_t sb[$];

    bin_to_bcd #(.WIDTH(14), .MAXVAL(9999)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every out_valid pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (!RESET && out_valid) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                checkOutput("unexpected out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("digits", {16'd0, thousands, hundreds, tens, ones}, {16'd0, e.digits});
                checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            end
        end
    end

    task automatic applyStimulus(input logic [13:0] v, input logic [15:0] d, input logic o, output int acc);
        exp_t e;
        int   n;
        bin_in   = v;
        in_valid = 1'b1;
        e.digits = d;
        e.ovf    = o;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept timeout", 32'd0, 32'd1);
        @(posedge clk);
        acc = cycle;
        #1;
    endtask

    task automatic waitOutput(input logic [15:0] hold, output int lat, output logic held);
        lat  = 0;
        held = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready || {thousands, hundreds, tens, ones} != hold) held = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("scoreboard drained", sb.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   acc, prev, lat, p0;
        logic held;

        vecs[0]  = '{14'd0,     16'h0000,  1'b0};
        vecs[1]  = '{14'd9,     16'h0009,  1'b0};
        vecs[2]  = '{14'd10,    16'h0010,  1'b0};
        vecs[3]  = '{14'd9999,  16'h9999,  1'b0};
        vecs[4]  = '{14'd5,     16'h0005,  1'b0};
        vecs[5]  = '{14'd99,    16'h0099,  1'b0};
        vecs[6]  = '{14'd100,   16'h0100,  1'b0};
        vecs[7]  = '{14'd1000,  16'h1000,  1'b0};
        vecs[8]  = '{14'd12345, EXP_12345, 1'b1};
        vecs[9]  = '{14'd4095,  16'h4095,  1'b0};
        vecs[10] = '{14'd8421,  16'h8421,  1'b0};
        vecs[11] = '{14'd16383, EXP_16383, 1'b1};

        RESET    = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;

        // Reset state after idling
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset digits", {16'd0, thousands, hundreds, tens, ones}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset ovf", {31'd0, ovf}, 32'd0);

        // Single conversion with latency and hold checks
        applyStimulus(14'd1234, 16'h1234, 1'b0, acc);
        in_valid = 1'b0;
        checkOutput("busy after accept", {31'd0, in_ready}, 32'd0);
        waitOutput(16'h0000, lat, held);
        checkOutput("latency 1234", lat, 32'd15);
        checkOutput("hold during conv", {31'd0, held}, 32'd1);
        checkOutput("ready at out_valid", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("out_valid width", {31'd0, out_valid}, 32'd0);

        // Table applied back-to-back with in_valid held high
        p0   = pulses;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].bin, vecs[i].digits, vecs[i].ovf, acc);
            if (i > 0) checkOutput("accept spacing", acc - prev, 32'd16);
            prev = acc;
        end
        in_valid = 1'b0;
        drain();
        checkOutput("pulse count table", pulses - p0, 32'd12);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ovf holds", {31'd0, ovf}, 32'd1);

        // Reset in the middle of a conversion
        applyStimulus(14'd42, 16'h0042, 1'b0, acc);
        in_valid = 1'b0;
        drain();
        p0 = pulses;
        applyStimulus(14'd5678, 16'h5678, 1'b0, acc);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 RESET = 1'b1;
        @(posedge clk);
        #1 RESET = 1'b0;
        void'(sb.pop_back());
        checkOutput("abort digits", {16'd0, thousands, hundreds, tens, ones}, 32'd0);
        checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort ovf", {31'd0, ovf}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no pulse after abort", pulses - p0, 32'd0);
        applyStimulus(14'd42, 16'h0042, 1'b0, acc);
        in_valid = 1'b0;
        waitOutput(16'h0000, lat, held);
        checkOutput("latency after abort", lat, 32'd15);
        drain();

        // Requests while busy are ignored
        p0 = pulses;
        applyStimulus(14'd321, 16'h0321, 1'b0, acc);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bin_in   = 14'd777;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 bin_in = 14'd999;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("single pulse 321", pulses - p0, 32'd1);
        checkOutput("digits 321 held", {16'd0, thousands, hundreds, tens, ones}, 32'h0321);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
